// File: rtl/chimpo_control.sv
// chimpo_control: multicycle CPU control FSM; define CHIMPO_MEMWAIT_EN to stall memory states until mem_ready
module chimpo_control #(
  parameter logic [3:0] OP_HALT = 4'hF
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] Op,
  input  logic       mem_ready,
  input  logic       mem_err,
  output logic       PCWrite,
  output logic [1:0] PCWriteCond,
  output logic [1:0] MemAddr,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [2:0] aluOpOut,
  output logic [1:0] PCSource,
  output logic [3:0] current_state,
  output logic       fault
);
  typedef enum logic [3:0] {
    FETCH  = 4'h0, DECODE = 4'h1, MEMADR = 4'h2, MEMRD = 4'h3,
    MEMWB  = 4'h4, MEMWR  = 4'h5, EXEC   = 4'h6, RCOMP = 4'h7,
    BRANCH = 4'h8, JUMP   = 4'h9, IEXEC  = 4'hA, ICOMP = 4'hB,
    HALT   = 4'hC, ERROR  = 4'hD
  } state_t;
  state_t state, next, s;
  logic ready;
`ifdef CHIMPO_MEMWAIT_EN
  assign ready = mem_ready;
`else
  logic unused_ready;
  assign unused_ready = mem_ready;
  assign ready = 1'b1;
`endif
  assign current_state = state;
  assign fault = (state == ERROR);
  // Next-state and outputs; reset forces FETCH outputs with the PC/IR loads held off
  always_comb begin
    s = reset ? state : FETCH;
    next = state;
    PCWrite = 1'b0;
    PCWriteCond = 2'd0;
    MemAddr = 2'd0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 3'd0;
    aluOpOut = 3'd0;
    PCSource = 2'd0;
    case (s)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = ready & ~mem_err;
        PCWrite = ready & ~mem_err;
        ALUSrcB = 3'd1;
        next = mem_err ? ERROR : ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 3'd3;
        next = (Op <= 4'd3) ? EXEC :
               (Op == 4'd4) ? IEXEC :
               (Op == 4'd5 || Op == 4'd6) ? MEMADR :
               (Op == 4'd7 || Op == 4'd8) ? BRANCH :
               (Op == 4'd9) ? JUMP :
               (Op == OP_HALT) ? HALT : ERROR;
      end
      MEMADR, IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 3'd2;
        next = (s == IEXEC) ? ICOMP : (Op == 4'd5) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemAddr = 2'd1;
        MemRead = 1'b1;
        next = mem_err ? ERROR : ready ? MEMWB : MEMRD;
      end
      MEMWR: begin
        MemAddr = 2'd1;
        MemWrite = 1'b1;
        next = mem_err ? ERROR : ready ? FETCH : MEMWR;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        next = FETCH;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        aluOpOut = Op[2:0];
        next = RCOMP;
      end
      RCOMP: begin
        RegWrite = 1'b1;
        RegDst = 1'b1;
        next = FETCH;
      end
      ICOMP: begin
        RegWrite = 1'b1;
        next = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        aluOpOut = 3'd1;
        PCSource = 2'd1;
        PCWriteCond = (Op == 4'd7) ? 2'b01 : 2'b10;
        next = FETCH;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSource = 2'd2;
        next = FETCH;
      end
      default: next = state;
    endcase
    if (!reset) begin
      PCWrite = 1'b0;
      IRWrite = 1'b0;
    end
  end
  // State register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!reset) state <= FETCH;
    else state <= next;
  end
endmodule

// File: tb/tb_chimpo_control.sv
// tb_chimpo_control: scoreboard bench for the chimpo_control FSM
module tb_chimpo_control;
  logic CLK = 1'b0;
  logic reset, mem_ready, mem_err;
  logic [3:0] Op;
  logic PCWrite, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, fault;
  logic [1:0] PCWriteCond, MemAddr, PCSource;
  logic [2:0] ALUSrcB, aluOpOut;
  logic [3:0] current_state;
  logic [20:0] outs;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct packed {logic [3:0] st; logic [3:0] op;} item_t;
  item_t sb[$];

  chimpo_control dut (
    .CLK(CLK), .reset(reset), .Op(Op), .mem_ready(mem_ready), .mem_err(mem_err),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .MemAddr(MemAddr), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .aluOpOut(aluOpOut),
    .PCSource(PCSource), .current_state(current_state), .fault(fault)
  );

  always #5 CLK = ~CLK;

  assign outs = {PCWrite, PCWriteCond, MemAddr, MemRead, MemWrite, IRWrite, RegWrite,
                 RegDst, MemtoReg, ALUSrcA, ALUSrcB, aluOpOut, PCSource, fault};

  // Expected outputs per state from the control table, assuming no reset, no fault, memory ready
  function automatic logic [20:0] spec_outs(input logic [3:0] st, input logic [3:0] op);
    logic pcw, mr, mw, irw, rw, rd, m2r, sa, f;
    logic [1:0] cond, ma, pcs;
    logic [2:0] sb_, alu;
    {pcw, mr, mw, irw, rw, rd, m2r, sa, f} = '0;
    cond = 2'd0; ma = 2'd0; pcs = 2'd0; sb_ = 3'd0; alu = 3'd0;
    case (st)
      4'h0: begin pcw = 1; mr = 1; irw = 1; sb_ = 3'd1; end
      4'h1: sb_ = 3'd3;
      4'h2, 4'hA: begin sa = 1; sb_ = 3'd2; end
      4'h3: begin ma = 2'd1; mr = 1; end
      4'h4: begin rw = 1; m2r = 1; end
      4'h5: begin ma = 2'd1; mw = 1; end
      4'h6: begin sa = 1; alu = op[2:0]; end
      4'h7: begin rw = 1; rd = 1; end
      4'h8: begin sa = 1; alu = 3'd1; pcs = 2'd1; cond = (op == 4'd7) ? 2'b01 : 2'b10; end
      4'h9: begin pcw = 1; pcs = 2'd2; end
      4'hB: rw = 1;
      4'hD: f = 1;
      default: ;
    endcase
    return {pcw, cond, ma, mr, mw, irw, rw, rd, m2r, sa, sb_, alu, pcs, f};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] st);
    item_t e;
    e.st = st;
    e.op = Op;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    item_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      #1;
      check({tag, " state"}, 32'(current_state), 32'(e.st));
      check({tag, " outs"}, 32'(outs), 32'(spec_outs(e.st, e.op)));
      @(negedge CLK);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    @(negedge CLK);
    #1;
    check({tag, " rst state"}, 32'(current_state), 32'h0);
    check({tag, " rst fault"}, 32'(fault), 32'h0);
    check({tag, " rst pcw"}, 32'(PCWrite), 32'h0);
    @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; Op = 4'd0; mem_ready = 1'b1; mem_err = 1'b0;
    @(negedge CLK);
    #1;
    check("reset state", 32'(current_state), 32'h0);
    check("reset pcw", 32'(PCWrite), 32'h0);
    check("reset irw", 32'(IRWrite), 32'h0);
    check("reset memread", 32'(MemRead), 32'h1);
    check("reset srcb", 32'(ALUSrcB), 32'h1);
    @(negedge CLK);
    reset = 1'b1;
    Op = 4'd0; push(4'h0); push(4'h1); push(4'h6); push(4'h7); drain("op0");
    Op = 4'd3; push(4'h0); push(4'h1); push(4'h6); push(4'h7); drain("op3");
    Op = 4'd4; push(4'h0); push(4'h1); push(4'hA); push(4'hB); drain("op4");
    Op = 4'd5; push(4'h0); push(4'h1); push(4'h2); push(4'h3); push(4'h4); drain("op5");
    Op = 4'd6; push(4'h0); push(4'h1); push(4'h2); push(4'h5); drain("op6");
    Op = 4'd7; push(4'h0); push(4'h1); push(4'h8); drain("op7");
    Op = 4'd8; push(4'h0); push(4'h1); push(4'h8); drain("op8");
    Op = 4'd9; push(4'h0); push(4'h1); push(4'h9); drain("op9");
    Op = 4'd1; push(4'h0); drain("errign f");
    mem_err = 1'b1;
    push(4'h1); push(4'h6); push(4'h7); drain("errign");
    mem_err = 1'b0;
    Op = 4'hB; push(4'h0); push(4'h1);
    for (int i = 0; i < 10; i++) push(4'hD);
    drain("opB");
    do_reset("err exit");
    Op = 4'hF; push(4'h0); push(4'h1);
    for (int i = 0; i < 5; i++) push(4'hC);
    drain("halt");
    do_reset("halt exit");
    Op = 4'd0;
    mem_err = 1'b1;
    #1;
    check("memerr state", 32'(current_state), 32'h0);
    check("memerr pcw", 32'(PCWrite), 32'h0);
    check("memerr irw", 32'(IRWrite), 32'h0);
    @(negedge CLK);
    mem_err = 1'b0;
    #1;
    check("memerr next", 32'(current_state), 32'hD);
    check("memerr fault", 32'(fault), 32'h1);
    @(negedge CLK);
    do_reset("memerr exit");
`ifdef CHIMPO_MEMWAIT_EN
    Op = 4'd5; push(4'h0); push(4'h1); push(4'h2); drain("wait pre");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(4'h3);
    drain("wait hold");
    mem_ready = 1'b1;
    push(4'h3); push(4'h4); push(4'h0); drain("wait go");
`endif
    Op = 4'd2; push(4'h0); push(4'h1); push(4'h6); push(4'h7); push(4'h0); drain("op2");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
